// File: rtl/mcu_ctrl_pkg.sv
// mcu_ctrl_pkg: shared state, opcode and control-field encodings for the MCU control unit.
`default_nettype none

package mcu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1001;
  localparam logic [3:0] OP_LD  = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_JZ  = 4'b1101;
  localparam logic [3:0] OP_JC  = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_FETCH = 2'b01;
  localparam logic [1:0] MEM_READ  = 2'b10;
  localparam logic [1:0] MEM_WRITE = 2'b11;

  localparam logic [1:0] REG_IDLE  = 2'b00;
  localparam logic [1:0] REG_READ  = 2'b01;
  localparam logic [1:0] REG_WRITE = 2'b10;

  localparam logic [3:0] ALU_PASS_B = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0010;

  // ADD..SHR occupy the contiguous range 0001..1000.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mcu_control.sv
// mcu_control: multi-cycle FSM sequencing fetch/decode/execute/memory/write-back
// and decoding the datapath enables, operation codes and mux selects.
`default_nettype none

module mcu_control
  import mcu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] OP,
  input  logic [1:0] SM,
  input  logic [1:0] Flag,
  output logic       PC_E,
  output logic       REG_E,
  output logic       ALU_E,
  output logic       MEM_E,
  output logic       PC_Ctr,
  output logic [1:0] Mem_Ctr,
  output logic [1:0] Reg_Ctr,
  output logic [3:0] ALU_Ctr,
  output logic       ALU_IN,
  output logic       MemToReg,
  output logic       Reg_Dst
);

  state_t     state;
  logic [3:0] op_q;
  logic       imm_q;

  logic unused_sm;
  assign unused_sm = SM[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      op_q  <= OP_NOP;
      imm_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          op_q  <= OP;
          imm_q <= SM[0];
          if (OP == OP_NOP)      state <= S_FETCH;
          else if (OP == OP_HLT) state <= S_HALT;
          else                   state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_alu_op(op_q))                     state <= S_WB;
          else if (op_q == OP_LD || op_q == OP_ST) state <= S_MEM;
          else                                     state <= S_FETCH;
        end
        S_MEM:   state <= (op_q == OP_LD) ? S_WB : S_FETCH;
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // DECODE looks at the live OP because the latch only captures it at the end of that cycle.
  always_comb begin
    PC_E     = 1'b0;
    REG_E    = 1'b0;
    ALU_E    = 1'b0;
    MEM_E    = 1'b0;
    PC_Ctr   = 1'b0;
    Mem_Ctr  = MEM_IDLE;
    Reg_Ctr  = REG_IDLE;
    ALU_Ctr  = ALU_PASS_B;
    ALU_IN   = 1'b0;
    MemToReg = 1'b0;
    Reg_Dst  = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          MEM_E   = 1'b1;
          Mem_Ctr = MEM_FETCH;
        end
        S_DECODE: begin
          REG_E   = 1'b1;
          Reg_Ctr = REG_READ;
          PC_E    = (OP == OP_NOP);
        end
        S_EXEC: begin
          if (is_alu_op(op_q)) begin
            ALU_E   = 1'b1;
            ALU_IN  = imm_q;
            ALU_Ctr = op_q;
          end else begin
            case (op_q)
              OP_CMP: begin
                ALU_E   = 1'b1;
                ALU_IN  = imm_q;
                ALU_Ctr = ALU_SUB;
                PC_E    = 1'b1;
              end
              OP_LD, OP_ST: begin
                ALU_E  = 1'b1;
                ALU_IN = imm_q;
              end
              OP_JMP: begin
                PC_E   = 1'b1;
                PC_Ctr = 1'b1;
              end
              OP_JZ: begin
                PC_E   = 1'b1;
                PC_Ctr = Flag[0];
              end
              OP_JC: begin
                PC_E   = 1'b1;
                PC_Ctr = Flag[1];
              end
              default: ;
            endcase
          end
        end
        S_MEM: begin
          if (op_q == OP_LD) begin
            MEM_E   = 1'b1;
            Mem_Ctr = MEM_READ;
          end else if (op_q == OP_ST) begin
            MEM_E   = 1'b1;
            Mem_Ctr = MEM_WRITE;
            PC_E    = 1'b1;
          end
        end
        S_WB: begin
          REG_E    = 1'b1;
          Reg_Ctr  = REG_WRITE;
          PC_E     = 1'b1;
          MemToReg = (op_q == OP_LD);
          Reg_Dst  = (op_q == OP_LD);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mcu_control.sv
// tb_mcu_control: directed, scoreboard-driven self-checking bench for mcu_control.
`default_nettype none

module tb_mcu_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] OP;
  logic [1:0] SM;
  logic [1:0] Flag;
  logic       PC_E, REG_E, ALU_E, MEM_E, PC_Ctr, ALU_IN, MemToReg, Reg_Dst;
  logic [1:0] Mem_Ctr, Reg_Ctr;
  logic [3:0] ALU_Ctr;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  mcu_control dut (
    .clk(clk), .rst(rst), .OP(OP), .SM(SM), .Flag(Flag),
    .PC_E(PC_E), .REG_E(REG_E), .ALU_E(ALU_E), .MEM_E(MEM_E),
    .PC_Ctr(PC_Ctr), .Mem_Ctr(Mem_Ctr), .Reg_Ctr(Reg_Ctr), .ALU_Ctr(ALU_Ctr),
    .ALU_IN(ALU_IN), .MemToReg(MemToReg), .Reg_Dst(Reg_Dst)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Field order: PC_E REG_E ALU_E MEM_E PC_Ctr Mem_Ctr Reg_Ctr ALU_Ctr ALU_IN MemToReg Reg_Dst
  function automatic logic [15:0] mk(input logic pce, rege, alue, meme, pcc,
                                     input logic [1:0] mc, rc, input logic [3:0] ac,
                                     input logic ai, m2r, rd);
    return {pce, rege, alue, meme, pcc, mc, rc, ac, ai, m2r, rd};
  endfunction

  logic [15:0] V_ZERO, V_FETCH, V_DECODE, V_WB_ALU;

  // Push the expectation, let the cycle settle, pop at negedge and compare, then advance.
  task automatic step(input string tag, input logic [15:0] expv);
    logic [15:0] e;
    string t;
    logic [15:0] obs;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    obs = {PC_E, REG_E, ALU_E, MEM_E, PC_Ctr, Mem_Ctr, Reg_Ctr, ALU_Ctr, ALU_IN, MemToReg, Reg_Dst};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", t, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  // FETCH, DECODE, then n post-decode states with the given expectations.
  task automatic instr(input string tag, input logic [3:0] op, input logic [1:0] sm,
                       input logic [1:0] flag, input int n,
                       input logic [15:0] e0, e1, e2);
    OP = op; SM = sm; Flag = flag;
    step({tag, "_fetch"}, V_FETCH);
    step({tag, "_decode"}, V_DECODE);
    if (n > 0) step({tag, "_s1"}, e0);
    if (n > 1) step({tag, "_s2"}, e1);
    if (n > 2) step({tag, "_s3"}, e2);
  endtask

  initial begin
    V_ZERO   = '0;
    V_FETCH  = mk(0,0,0,1,0, 2'b01, 2'b00, 4'b0000, 0,0,0);
    V_DECODE = mk(0,1,0,0,0, 2'b00, 2'b01, 4'b0000, 0,0,0);
    V_WB_ALU = mk(1,1,0,0,0, 2'b00, 2'b10, 4'b0000, 0,0,0);

    rst = 1'b1; OP = 4'b0000; SM = 2'b00; Flag = 2'b00;
    #1;
    step("reset_c0", V_ZERO);
    step("reset_c1", V_ZERO);
    rst = 1'b0;

    instr("add_imm", 4'b0001, 2'b01, 2'b00, 2,
          mk(0,0,1,0,0, 2'b00, 2'b00, 4'b0001, 1,0,0), V_WB_ALU, V_ZERO);
    instr("xor_reg", 4'b0101, 2'b10, 2'b00, 2,
          mk(0,0,1,0,0, 2'b00, 2'b00, 4'b0101, 0,0,0), V_WB_ALU, V_ZERO);
    instr("ld", 4'b1010, 2'b00, 2'b00, 3,
          mk(0,0,1,0,0, 2'b00, 2'b00, 4'b0000, 0,0,0),
          mk(0,0,0,1,0, 2'b10, 2'b00, 4'b0000, 0,0,0),
          mk(1,1,0,0,0, 2'b00, 2'b10, 4'b0000, 0,1,1));
    instr("st", 4'b1011, 2'b01, 2'b00, 2,
          mk(0,0,1,0,0, 2'b00, 2'b00, 4'b0000, 1,0,0),
          mk(1,0,0,1,0, 2'b11, 2'b00, 4'b0000, 0,0,0), V_ZERO);
    OP = 4'b0000;
    step("nop_fetch", V_FETCH);
    step("nop_decode", mk(1,1,0,0,0, 2'b00, 2'b01, 4'b0000, 0,0,0));
    instr("cmp", 4'b1001, 2'b01, 2'b00, 1,
          mk(1,0,1,0,0, 2'b00, 2'b00, 4'b0010, 1,0,0), V_ZERO, V_ZERO);
    instr("jmp", 4'b1100, 2'b00, 2'b00, 1,
          mk(1,0,0,0,1, 2'b00, 2'b00, 4'b0000, 0,0,0), V_ZERO, V_ZERO);
    instr("jz_taken", 4'b1101, 2'b00, 2'b01, 1,
          mk(1,0,0,0,1, 2'b00, 2'b00, 4'b0000, 0,0,0), V_ZERO, V_ZERO);
    instr("jz_not", 4'b1101, 2'b00, 2'b00, 1,
          mk(1,0,0,0,0, 2'b00, 2'b00, 4'b0000, 0,0,0), V_ZERO, V_ZERO);
    instr("jc_taken", 4'b1110, 2'b00, 2'b10, 1,
          mk(1,0,0,0,1, 2'b00, 2'b00, 4'b0000, 0,0,0), V_ZERO, V_ZERO);
    instr("jc_not", 4'b1110, 2'b00, 2'b01, 1,
          mk(1,0,0,0,0, 2'b00, 2'b00, 4'b0000, 0,0,0), V_ZERO, V_ZERO);

    // Opcode changes after DECODE must not disturb the in-flight ADD.
    OP = 4'b0001; SM = 2'b00; Flag = 2'b00;
    step("opchg_fetch", V_FETCH);
    step("opchg_decode", V_DECODE);
    OP = 4'b1100;
    step("opchg_exec", mk(0,0,1,0,0, 2'b00, 2'b00, 4'b0001, 0,0,0));
    step("opchg_wb", V_WB_ALU);

    // Reset during WB aborts the instruction.
    OP = 4'b0011;
    step("rstwb_fetch", V_FETCH);
    step("rstwb_decode", V_DECODE);
    step("rstwb_exec", mk(0,0,1,0,0, 2'b00, 2'b00, 4'b0011, 0,0,0));
    rst = 1'b1;
    step("rstwb_wb", V_ZERO);
    rst = 1'b0;
    step("rstwb_refetch", V_FETCH);

    // HLT parks the FSM until reset, regardless of OP/Flag activity.
    OP = 4'b1111; SM = 2'b00;
    step("hlt_decode", V_DECODE);
    for (int i = 0; i < 12; i++) begin
      OP   = 4'($urandom_range(0, 15));
      Flag = 2'($urandom_range(0, 3));
      step($sformatf("hlt_idle%0d", i), V_ZERO);
    end
    rst = 1'b1;
    step("hlt_rst", V_ZERO);
    rst = 1'b0;
    OP = 4'b0000;
    step("hlt_resume_fetch", V_FETCH);
    step("hlt_resume_decode", mk(1,1,0,0,0, 2'b00, 2'b01, 4'b0000, 0,0,0));
    step("hlt_resume_next", V_FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
